// File: rtl/line_arbiter.sv
// Shares one cache-line memory port between I-cache (read) and D-cache (read/write); D wins, with a bounded starvation guard for I.
// Latency: memory command one cycle after the request; requester resp/rdata combinational with m_resp.
// Backpressure: requests are held until resp, the memory command is held until m_resp. LINE_ARBITER_PERF_EN adds perf counters.
module line_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp
`ifdef LINE_ARBITER_PERF_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_contend
`endif
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

    state_t            state, state_nxt;
    logic [3:0]        d_streak, d_streak_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [LINE_W-1:0] wdata_nxt;
    logic              d_pend;
    logic              grant_i;
    logic              grant_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            d_streak  <= '0;
            m_address <= '0;
            m_wdata   <= '0;
        end else begin
            state     <= state_nxt;
            d_streak  <= d_streak_nxt;
            m_address <= addr_nxt;
            m_wdata   <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        d_streak_nxt = d_streak;
        addr_nxt     = m_address;
        wdata_nxt    = m_wdata;
        d_pend       = d_read | d_write;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        m_read       = 1'b0;
        m_write      = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        i_rdata      = '0;
        d_rdata      = '0;
        case (state)
            IDLE: begin
                // D loses a contested grant only once its streak has saturated
                if (d_pend && !(i_read && d_streak == STREAK_MAX)) begin
                    grant_d = 1'b1;
                end else if (i_read) begin
                    grant_i = 1'b1;
                end
                if (grant_d) begin
                    state_nxt = d_write ? SERVE_D_WR : SERVE_D_RD;
                    addr_nxt  = d_address;
                    if (d_write) begin
                        wdata_nxt = d_wdata;
                    end
                end else if (grant_i) begin
                    state_nxt = SERVE_I;
                    addr_nxt  = i_address;
                end
                if (!i_read || grant_i) begin
                    d_streak_nxt = '0;
                end else if (grant_d && d_streak != STREAK_MAX) begin
                    d_streak_nxt = d_streak + 4'd1;
                end
            end
            SERVE_I: begin
                m_read = 1'b1;
                if (m_resp) begin
                    i_resp    = 1'b1;
                    i_rdata   = m_rdata;
                    state_nxt = IDLE;
                end
            end
            SERVE_D_RD: begin
                m_read = 1'b1;
                if (m_resp) begin
                    d_resp    = 1'b1;
                    d_rdata   = m_rdata;
                    state_nxt = IDLE;
                end
            end
            SERVE_D_WR: begin
                m_write = 1'b1;
                if (m_resp) begin
                    d_resp    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef LINE_ARBITER_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_i_grants <= '0;
            perf_d_grants <= '0;
            perf_contend  <= '0;
        end else begin
            if (grant_i) begin
                perf_i_grants <= perf_i_grants + 32'd1;
            end
            if (grant_d) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
            if (state == IDLE && i_read && d_pend) begin
                perf_contend <= perf_contend + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_arbiter.sv
// Bench for line_arbiter: memory model plus grant scoreboard, a vector table and hand-written corner sequences.
module tb_line_arbiter;

    logic         clk;
    logic         reset_n;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         m_read;
    logic         m_write;
    logic [31:0]  m_address;
    logic [255:0] m_wdata;
    logic [255:0] m_rdata;
    logic         m_resp;
`ifdef LINE_ARBITER_PERF_EN
    logic [31:0]  perf_i_grants;
    logic [31:0]  perf_d_grants;
    logic [31:0]  perf_contend;
`endif

    line_arbiter #(.ADDR_W(32), .LINE_W(256), .STARVE_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_resp(m_resp)
`ifdef LINE_ARBITER_PERF_EN
        ,
        .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants), .perf_contend(perf_contend)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           is_d;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } grant_t;

    typedef struct {
        bit           i_rd;
        logic [31:0]  i_addr;
        bit           d_rd;
        bit           d_wr;
        logic [31:0]  d_addr;
        logic [255:0] d_wd;
        int           n_exp;
        bit           exp_wr0;
    } vec_t;

    int     total = 0;
    int     bad = 0;
    grant_t gq[$];
    grant_t cur;
    bit     act = 0;
    bit     prev_cmd = 0;
    bit     d_hold = 0;
    bit     stray = 0;
    bit     mem_act = 0;
    int     mem_cnt = 0;
    int     mem_lat = 2;
    int     n_i = 0;
    int     n_d = 0;
    vec_t   vecs[7];

    function automatic logic [255:0] line_of(input logic [31:0] a);
        if (a == 32'h0000_1040) return {32{8'hA5}};
        return {8{a ^ 32'hC3C3_0000}};
    endfunction

    task automatic check(input string nm, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event not seen within its cycle budget", nm);
    endtask

    function automatic grant_t mk(input bit is_d, input bit wr, input logic [31:0] a, input logic [255:0] wd);
        grant_t g;
        g.is_d = is_d;
        g.wr = wr;
        g.addr = a;
        g.wdata = wd;
        return g;
    endfunction

    // One cycle: drive memory at the falling edge, then sample and score mid low phase.
    task automatic tick();
        bit cmd;
        bit exp_i;
        bit exp_d;
        @(negedge clk);
        if (m_resp) begin
            m_resp = 1'b0;
            m_rdata = '0;
        end else if (stray) begin
            m_resp = 1'b1;
            m_rdata = line_of(32'h0000_0BAD);
            stray = 0;
        end else if (m_read || m_write) begin
            if (!mem_act) begin
                mem_act = 1;
                mem_cnt = mem_lat - 1;
            end else if (mem_cnt == 0) begin
                m_resp = 1'b1;
                m_rdata = m_read ? line_of(m_address) : '0;
                mem_act = 0;
            end else begin
                mem_cnt--;
            end
        end
        #1;
        cmd = m_read | m_write;
        if (cmd && !prev_cmd) begin
            if (act) fail_now("grant_without_resp");
            if (gq.size() == 0) begin
                fail_now("grant_unexpected");
            end else begin
                cur = gq.pop_front();
                act = 1;
                if (cur.is_d) n_d++; else n_i++;
                check("grant_m_write", m_write, cur.wr);
                check("grant_m_read", m_read, !cur.wr);
                check("grant_m_address", m_address, cur.addr);
                if (cur.wr) check("grant_m_wdata", m_wdata, cur.wdata);
            end
        end
        exp_i = m_resp && act && !cur.is_d;
        exp_d = m_resp && act && cur.is_d;
        check("i_resp", i_resp, exp_i);
        check("d_resp", d_resp, exp_d);
        check("i_rdata", i_rdata, exp_i ? line_of(cur.addr) : 256'd0);
        if (!(exp_d && cur.wr)) check("d_rdata", d_rdata, exp_d ? line_of(cur.addr) : 256'd0);
        if (m_resp && act) act = 0;
        prev_cmd = cmd;
        if (i_resp) i_read = 1'b0;
        if (d_resp && !d_hold) begin
            d_read = 1'b0;
            d_write = 1'b0;
        end
    endtask

    initial begin
        int resp_at;
        int n_ir;
        int n_dr;
        bit done;
        reset_n = 1'b0;
        i_read = 0; i_address = '0;
        d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
        m_rdata = '0; m_resp = 1'b0;

        vecs[0] = '{1, 32'h0000_2480, 0, 0, 32'h0, 256'h0, 1, 0};
        vecs[1] = '{0, 32'h0, 1, 0, 32'h0000_4000, 256'h0, 1, 0};
        vecs[2] = '{0, 32'h0, 0, 1, 32'h0000_5000, {8{32'hDEADBEEF}}, 1, 1};
        vecs[3] = '{1, 32'h0000_6040, 1, 0, 32'h0000_7000, 256'h0, 2, 0};
        vecs[4] = '{1, 32'h0000_8040, 0, 1, 32'h0000_9000, {8{32'h0123_4567}}, 2, 1};
        vecs[5] = '{0, 32'h0, 1, 1, 32'h0000_A000, {8{32'h89AB_CDEF}}, 1, 1};
        vecs[6] = '{1, 32'h0000_B040, 1, 1, 32'h0000_C000, {8{32'h5555_AAAA}}, 2, 1};

        #3;
        check("rst_m_read", m_read, 0);
        check("rst_m_write", m_write, 0);
        check("rst_resp", {i_resp, d_resp}, 0);
        check("rst_rdata", i_rdata | d_rdata, 0);
        check("rst_m_address", m_address, 0);
        check("rst_m_wdata", m_wdata, 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("idle_cmd", m_read | m_write, 0);

        // Single I read, memory answers five cycles after m_read.
        mem_lat = 5;
        gq.push_back(mk(0, 0, 32'h0000_1040, '0));
        i_read = 1'b1; i_address = 32'h0000_1040;
        resp_at = 0; n_ir = 0; n_dr = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) check("i_latency_m_read", m_read, 1);
            if (i_resp) begin n_ir++; resp_at = k; end
            if (d_resp) n_dr++;
        end
        check("i_resp_pulses", n_ir, 1);
        check("i_resp_cycle", resp_at, 6);
        check("i_read_d_resp_pulses", n_dr, 0);
        mem_lat = 2;

        // D writeback followed by a D read: one IDLE cycle in between.
        gq.push_back(mk(1, 1, 32'h0000_2000, {32{8'h11}}));
        gq.push_back(mk(1, 0, 32'h0000_3000, '0));
        d_write = 1'b1; d_address = 32'h0000_2000; d_wdata = {32{8'h11}};
        done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            tick();
            if (d_resp) done = 1;
        end
        if (!done) fail_now("wb_resp");
        d_write = 1'b0; d_read = 1'b1; d_address = 32'h0000_3000;
        tick();
        check("wb_idle_gap", m_read | m_write, 0);
        tick();
        check("wb_then_rd_m_read", m_read, 1);
        for (int k = 0; k < 30 && d_read; k++) tick();
        if (d_read) begin fail_now("wb_rd_resp"); d_read = 1'b0; end

        // Starvation guard: four contested D grants, then I, then the waiting D.
        for (int k = 0; k < 4; k++) gq.push_back(mk(1, 0, 32'h0000_B000, '0));
        gq.push_back(mk(0, 0, 32'h0000_1100, '0));
        gq.push_back(mk(1, 0, 32'h0000_B000, '0));
        d_hold = 1;
        i_read = 1'b1; i_address = 32'h0000_1100;
        d_read = 1'b1; d_address = 32'h0000_B000;
        for (int k = 0; k < 150 && (i_read || d_read); k++) begin
            tick();
            if (!i_read) d_hold = 0;
        end
        if (i_read || d_read) begin fail_now("starve_done"); i_read = 0; d_read = 0; d_hold = 0; end
        tick();
        check("starve_queue_drained", gq.size(), 0);

        // Vector table: single and contested requests from IDLE.
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].d_rd || vecs[v].d_wr)
                gq.push_back(mk(1, vecs[v].exp_wr0, vecs[v].d_addr, vecs[v].d_wd));
            else
                gq.push_back(mk(0, 0, vecs[v].i_addr, '0));
            if (vecs[v].n_exp == 2) gq.push_back(mk(0, 0, vecs[v].i_addr, '0));
            i_read = vecs[v].i_rd; i_address = vecs[v].i_addr;
            d_read = vecs[v].d_rd; d_write = vecs[v].d_wr;
            d_address = vecs[v].d_addr; d_wdata = vecs[v].d_wd;
            tick();
            check($sformatf("vec%0d_latency", v), m_read | m_write, 1);
            for (int k = 0; k < 40 && (i_read || d_read || d_write); k++) tick();
            if (i_read || d_read || d_write) begin
                fail_now($sformatf("vec%0d_done", v));
                i_read = 0; d_read = 0; d_write = 0;
            end
            tick();
            check($sformatf("vec%0d_queue_drained", v), gq.size(), 0);
        end

        // Asynchronous reset during a D write.
        gq.push_back(mk(1, 1, 32'h0000_C000, {8{32'hFEED_F00D}}));
        d_write = 1'b1; d_address = 32'h0000_C000; d_wdata = {8{32'hFEED_F00D}};
        tick();
        check("rst_mid_m_write_before", m_write, 1);
        #1;
        reset_n = 1'b0;
        m_resp = 1'b1;
        #1;
        check("rst_mid_m_write", m_write, 0);
        check("rst_mid_d_resp", d_resp, 0);
        check("rst_mid_m_address", m_address, 0);
        check("rst_mid_m_wdata", m_wdata, 0);
`ifdef LINE_ARBITER_PERF_EN
        check("rst_mid_perf", {perf_i_grants, perf_d_grants, perf_contend}, 0);
`endif
        m_resp = 1'b0; m_rdata = '0;
        d_write = 1'b0;
        act = 0; mem_act = 0; prev_cmd = 0; n_i = 0; n_d = 0;
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_mid_after_cmd", m_read | m_write, 0);

        // Stray m_resp in IDLE produces no completion.
        stray = 1;
        tick();
        check("stray_m_resp_driven", m_resp, 1);
        check("stray_resp", {i_resp, d_resp}, 0);
        tick();
        check("stray_state_idle", m_read | m_write, 0);

        // A short run after reset to exercise the counters.
        gq.push_back(mk(1, 0, 32'h0000_D000, '0));
        gq.push_back(mk(0, 0, 32'h0000_D040, '0));
        i_read = 1'b1; i_address = 32'h0000_D040;
        d_read = 1'b1; d_address = 32'h0000_D000;
        for (int k = 0; k < 40 && (i_read || d_read); k++) tick();
        if (i_read || d_read) begin fail_now("post_rst_done"); i_read = 0; d_read = 0; end
        tick();
        check("post_rst_grants", {n_i[7:0], n_d[7:0]}, {8'd1, 8'd1});
`ifdef LINE_ARBITER_PERF_EN
        check("perf_i_grants", perf_i_grants, 1);
        check("perf_d_grants", perf_d_grants, 1);
        check("perf_contend", perf_contend, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
